// File: rtl/sqrt_iter_s0.sv
// Iterative restoring square root: 16-bit radicand -> 8-bit root + 9-bit remainder.
// One root bit is resolved per cycle, MSB first, behind a valid/ready handshake.
module sqrt_iter_s0 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [15:0] i_radicand,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_root,
    output logic [8:0]  o_remainder,
    output logic        o_root_en,
    output logic [7:0]  o_root_next
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_rad;
    logic [7:0]          r_root;
    logic [8:0]          r_rem;
    logic [2:0]          r_cnt;

    logic [1:0]          w_pair;
    logic [10:0]         w_cat;
    logic signed [10:0]  w_trial;
    logic                w_fit;
    logic [7:0]          w_root_new;
    logic [8:0]          w_rem_new;

    assign w_pair  = r_rad[{r_cnt, 1'b0} +: 2];
    assign w_cat   = {r_rem, w_pair};
    assign w_trial = $signed(w_cat) - $signed({1'b0, r_root, 2'b01});
    // rem <= 2*root keeps any accepted trial below 0x200; bit 9 guards the 9-bit store.
    assign w_fit      = ~w_trial[10] & ~w_trial[9];
    assign w_root_new = {r_root[6:0], w_fit};
    assign w_rem_new  = w_fit ? w_trial[8:0] : w_cat[8:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_in_valid)     w_state_nxt = S_ITER;
            S_ITER: if (r_cnt == 3'd0)  w_state_nxt = S_DONE;
            S_DONE: if (i_out_ready)    w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_root_en   = 1'b0;
        o_root_next = r_root;
        case (r_state)
            S_IDLE: o_in_ready = 1'b1;
            S_ITER: begin
                o_root_en   = 1'b1;
                o_root_next = w_root_new;
            end
            S_DONE: o_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_IDLE && i_in_valid) begin
            r_rad  <= i_radicand;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= 3'd7;
        end else if (r_state == S_ITER) begin
            r_root <= w_root_new;
            r_rem  <= w_rem_new;
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_root      = r_root;
    assign o_remainder = r_rem;

endmodule

// File: tb/tb_sqrt_iter_s0.sv
// Self-checking bench for sqrt_iter_s0: directed corner cases plus randomized
// radicands with backpressure, compared against an arithmetic integer-sqrt model.
module tb_sqrt_iter_s0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] radicand;
    logic        in_ready, out_valid, root_en;
    logic [7:0]  root, root_next;
    logic [8:0]  remainder;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] rn_log [8];

    sqrt_iter_s0 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_radicand(radicand), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_root(root), .o_remainder(remainder), .o_root_en(root_en), .o_root_next(root_next)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Starts and ends just after a falling edge; logs root_next of each ITER cycle.
    task automatic do_op(input logic [15:0] rad, input int hold,
                         output logic [7:0] rt, output logic [8:0] rm,
                         output int en_cyc, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_valid = 1'b1; radicand = rad;
        @(negedge clk);
        in_valid = 1'b0; radicand = 16'($urandom);
        lat = 1; en_cyc = 0;
        while (!out_valid && lat < 20) begin
            if (root_en) begin
                if (en_cyc < 8) rn_log[en_cyc] = root_next;
                en_cyc++;
            end
            in_valid = 1'($urandom); radicand = 16'($urandom);
            @(negedge clk); lat++;
        end
        rt = root; rm = remainder;
        repeat (hold) @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; radicand = '0;
        #12;
        n_chk++;
        if ({out_valid, root_en, root, remainder, root_next} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b en=%b root=%h rem=%h rn=%h, want all zero",
                     out_valid, root_en, root, remainder, root_next);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_corners;
        logic [7:0] rt; logic [8:0] rm; int en, lat;
        do_op(16'h0000, 0, rt, rm, en, lat);
        n_chk++;
        if (lat !== 9 || rt !== 8'h00 || rm !== 9'h000) begin
            n_fail++; $display("FAIL zero: lat=%0d root=%h rem=%h, want 9/00/000", lat, rt, rm);
        end
        do_op(16'hFFFF, 0, rt, rm, en, lat);
        n_chk++;
        if (rt !== 8'hFF || rm !== 9'h1FE) begin
            n_fail++; $display("FAIL ffff: root=%h rem=%h, want ff/1fe", rt, rm);
        end
        n_chk++;
        if (en !== 8) begin
            n_fail++; $display("FAIL ffff_root_en: got %0d cycles want 8", en);
        end
        do_op(16'd143, 0, rt, rm, en, lat);
        n_chk++;
        if (rt !== 8'd11 || rm !== 9'd22) begin
            n_fail++; $display("FAIL r143: root=%0d rem=%0d, want 11/22", rt, rm);
        end
    endtask

    task automatic test_root_next;
        logic [7:0] rt; logic [8:0] rm; int en, lat;
        do_op(16'd144, 0, rt, rm, en, lat);
        n_chk++;
        if (rt !== 8'd12 || rm !== 9'd0) begin
            n_fail++; $display("FAIL r144: root=%0d rem=%0d, want 12/0", rt, rm);
        end
        for (int j = 0; j < 8; j++) begin
            n_chk++;
            if (rn_log[j] !== 8'(isqrt(144 >> (2 * (7 - j))))) begin
                n_fail++;
                $display("FAIL root_next[%0d]: got %h want %h", j, rn_log[j],
                         8'(isqrt(144 >> (2 * (7 - j)))));
            end
        end
        n_chk++;
        if (rn_log[7] !== 8'h0C) begin
            n_fail++; $display("FAIL root_next_last: got %h want 0c", rn_log[7]);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] r0; logic [8:0] m0; int w;
        w = 0;
        in_valid = 1'b1; radicand = 16'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        r0 = root; m0 = remainder;
        n_chk++;
        if (r0 !== 8'd31 || m0 !== 9'd39 || root_next !== 8'd31) begin
            n_fail++; $display("FAIL bp_result: root=%0d rem=%0d rn=%0d, want 31/39/31", r0, m0, root_next);
        end
        in_valid = 1'b1; radicand = 16'h1234;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || root !== r0 || remainder !== m0 || root_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: ov=%b ir=%b root=%0d rem=%0d en=%b, want 1/0/%0d/%0d/0",
                         out_valid, in_ready, root, remainder, root_en, r0, m0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || root_en !== 1'b0 || out_valid !== 1'b0 || root !== r0 || remainder !== m0) begin
            n_fail++;
            $display("FAIL no_overlap: ir=%b en=%b ov=%b root=%0d rem=%0d, want 1/0/0/%0d/%0d",
                     in_ready, root_en, out_valid, root, remainder, r0, m0);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_iter;
        logic [7:0] rt; logic [8:0] rm; int en, lat; int seen;
        in_valid = 1'b1; radicand = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, root_en, root, remainder, root_next} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_iter: ov=%b en=%b root=%h rem=%h rn=%h, want all zero",
                     out_valid, root_en, root, remainder, root_next);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge clk); if (out_valid) seen++; end
        n_chk++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_discard: out_valid seen %0d cycles, want 0", seen);
        end
        do_op(16'h0100, 0, rt, rm, en, lat);
        n_chk++;
        if (rt !== 8'h10 || rm !== 9'h000 || lat !== 9) begin
            n_fail++; $display("FAIL after_reset: root=%h rem=%h lat=%0d, want 10/000/9", rt, rm, lat);
        end
    endtask

    task automatic test_random;
        logic [7:0] rt; logic [8:0] rm; int en, lat; logic [15:0] x; int er, em;
        for (int i = 0; i < 3000; i++) begin
            x = 16'($urandom);
            if (i < 4) x = (i == 0) ? 16'hFFFE : (i == 1) ? 16'h0001 : (i == 2) ? 16'hFE01 : 16'hFE00;
            do_op(x, $urandom_range(0, 3), rt, rm, en, lat);
            er = isqrt(int'(x));
            em = int'(x) - er * er;
            n_chk++;
            if (int'(rt) != er || int'(rm) != em || lat != 9 || en != 8 ||
                int'(rt) * int'(rt) + int'(rm) != int'(x) || int'(rm) > 2 * int'(rt)) begin
                n_fail++;
                $display("FAIL random x=%h: root=%0d rem=%0d lat=%0d en=%0d, want root=%0d rem=%0d lat=9 en=8",
                         x, rt, rm, lat, en, er, em);
            end
        end
    endtask

    initial begin
        test_reset;
        test_corners;
        test_root_next;
        test_backpressure;
        test_reset_mid_iter;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
